prog_mem_loader: RTL

- Parametrised, clocked instruction memory for the CPU.
- Replaces the hard-coded combinational program store with a RAM that the host loads at run time through a byte-serial loader port.
- The fetch stage reads it through a registered request/response port with 1-cycle latency.
- Sits between the host/test loader and the CPU fetch logic. Out-of-program fetches return the END line so the core halts safely.

---
 rtl/prog_mem_loader_pkg.sv | 24 ++
 rtl/prog_mem_ram.sv | 68 ++++++
 rtl/prog_mem_loader.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/prog_mem_loader_pkg.sv
// Shared parameters and types for the program memory loader.
//   DEF_*          : default geometry used by prog_mem_loader
//   BYTES_PER_LINE : bytes per instruction word at the default width
//   load_state_e   : loader FSM states
package prog_mem_loader_pkg;

  localparam int unsigned DEF_LINE_WIDTH = 32;
  localparam int unsigned DEF_IP_WIDTH   = 8;
  localparam int unsigned DEF_DEPTH      = 256;
  localparam logic [DEF_LINE_WIDTH-1:0] DEF_END_LINE = '1;
  localparam int unsigned BYTES_PER_LINE = DEF_LINE_WIDTH / 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } load_state_e;

  // Number of loader bytes that make up one word of the given width.
  function automatic int unsigned bytes_per_line(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/prog_mem_ram.sv
// Single-port synchronous RAM with registered read.
// Write has priority over read on the shared address.
// Optional macro PROG_MEM_PARITY_EN: stores an even-parity bit per word and
// exposes perr_c, the recomputed parity mismatch of the registered read word.
// Ports:
//   clk    : clock
//   we     : write enable, writes wdata to mem[addr]
//   re     : read enable, captures mem[addr] into the read register
//   addr   : word address
//   wdata  : write word
//   rdata  : registered read word (holds while re is low)
//   perr_c : parity mismatch of rdata (parity build only)
module prog_mem_ram
  import prog_mem_loader_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_LINE_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = DEF_IP_WIDTH
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
`ifdef PROG_MEM_PARITY_EN
  output logic             perr_c,
`endif
  output logic [WIDTH-1:0] rdata
);

`ifdef PROG_MEM_PARITY_EN
  localparam int unsigned SW = WIDTH + 1;
`else
  localparam int unsigned SW = WIDTH;
`endif

  logic [SW-1:0] mem [DEPTH];
  logic [SW-1:0] wr_word;
  logic [SW-1:0] rd_q;
  logic [SW-1:0] rd_d;

  // Stored word, with parity bit on top when enabled.
  always_comb begin
`ifdef PROG_MEM_PARITY_EN
    wr_word = {^wdata, wdata};
`else
    wr_word = wdata;
`endif
  end

  always_comb begin
    rd_d = rd_q;
    if (re && !we) rd_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_word;
    rd_q <= rd_d;
  end

  assign rdata = rd_q[WIDTH-1:0];

`ifdef PROG_MEM_PARITY_EN
  // Even parity over data plus stored bit must be zero.
  assign perr_c = ^rd_q;
`endif

endmodule

// File: rtl/prog_mem_loader.sv
// Run-time loadable instruction memory for the CPU fetch stage.
// The host streams bytes (MSB first) through the loader port; the fetch
// stage reads with one-cycle latency. Fetches outside the loaded program,
// or while not in RUN, return END_LINE so the core halts safely.
// Optional macro PROG_MEM_PARITY_EN adds per-word parity and fetch_perr.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   load_start/valid/byte/stop : byte-serial loader
//   load_err                : sticky overflow / partial-word flag
//   prog_len                : complete words loaded
//   ready                   : high in RUN
//   fetch_req, fetch_ip     : fetch request and word address
//   fetch_valid, fetch_line : fetch response, one cycle after request
//   fetch_perr              : parity error on response (parity build only)
module prog_mem_loader
  import prog_mem_loader_pkg::*;
#(
  parameter int unsigned LINE_WIDTH          = DEF_LINE_WIDTH,
  parameter int unsigned IP_WIDTH            = DEF_IP_WIDTH,
  parameter int unsigned DEPTH               = DEF_DEPTH,
  parameter logic [LINE_WIDTH-1:0] END_LINE  = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [7:0]            load_byte,
  input  logic                  load_stop,
  output logic                  load_err,
  output logic [IP_WIDTH:0]     prog_len,
  output logic                  ready,
  input  logic                  fetch_req,
  input  logic [IP_WIDTH-1:0]   fetch_ip,
`ifdef PROG_MEM_PARITY_EN
  output logic                  fetch_perr,
`endif
  output logic                  fetch_valid,
  output logic [LINE_WIDTH-1:0] fetch_line
);

  localparam int unsigned BPL = bytes_per_line(LINE_WIDTH);
  localparam int unsigned CW  = $clog2(BPL + 1);
  localparam int unsigned PW  = IP_WIDTH + 1;
  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  load_state_e           state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [LINE_WIDTH-1:0] word_q, word_d;
  logic                  err_q, err_d;
  logic                  ready_q, ready_d;
  logic                  fvalid_q, fvalid_d;
  logic                  hit_q, hit_d;

  logic [LINE_WIDTH-1:0] word_sh;
  logic                  ram_we, ram_re, ram_perr_c;
  logic [AW-1:0]         ram_addr;
  logic [LINE_WIDTH-1:0] ram_rdata;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      ptr_q    <= '0;
      cnt_q    <= '0;
      word_q   <= '0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      fvalid_q <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      fvalid_q <= fvalid_d;
      hit_q    <= hit_d;
    end
  end

  // Next state: load_start always wins over load_stop.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (load_start) state_d = LOAD;
      LOAD:    if (!load_start && load_stop) state_d = RUN;
      RUN:     if (load_start) state_d = LOAD;
      default: state_d = EMPTY;
    endcase
  end

  // Word assembler, write control and fetch bookkeeping.
  always_comb begin
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    err_d    = err_q;
    ram_we   = 1'b0;
    word_sh  = LINE_WIDTH'({word_q, load_byte});
    if (load_start) begin
      ptr_d = '0;
      cnt_d = '0;
      err_d = 1'b0;
    end else if (state_q == LOAD) begin
      if (load_valid) begin
        word_d = word_sh;
        if (cnt_q == CW'(BPL - 1)) begin
          cnt_d = '0;
          if (ptr_q < PW'(DEPTH)) begin
            ram_we = !rst;
            ptr_d  = PW'(ptr_q + 1'b1);
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = CW'(cnt_q + 1'b1);
        end
      end
      // Stop is evaluated after any byte in the same cycle.
      if (load_stop) begin
        if (cnt_d != '0) err_d = 1'b1;
        cnt_d = '0;
      end
    end
    ready_d  = (state_d == RUN);
    fvalid_d = fetch_req;
    hit_d    = hit_q;
    // A fetch racing a reload sees the program as already gone.
    if (fetch_req) hit_d = (state_q == RUN) && !load_start && (PW'(fetch_ip) < ptr_q);
    ram_re   = fetch_req && hit_d;
    ram_addr = ram_we ? AW'(ptr_q) : AW'(fetch_ip);
  end

  prog_mem_ram #(
    .WIDTH (LINE_WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (word_sh),
`ifdef PROG_MEM_PARITY_EN
    .perr_c(ram_perr_c),
`endif
    .rdata (ram_rdata)
  );

`ifndef PROG_MEM_PARITY_EN
  assign ram_perr_c = 1'b0;
`endif

  // Outputs; hit_q and the RAM read register only move on a request, so
  // fetch_line holds between responses.
  always_comb begin
    load_err    = err_q;
    prog_len    = ptr_q;
    ready       = ready_q;
    fetch_valid = fvalid_q;
    fetch_line  = (hit_q && !ram_perr_c) ? ram_rdata : END_LINE;
`ifdef PROG_MEM_PARITY_EN
    fetch_perr  = hit_q && ram_perr_c;
`endif
  end

endmodule
